stream_router: RTL and testbench
================================

# stream_router

Registered, parametrised N_IN→N_OUT channel router between the PID core and the output preprocessor. Each output takes one input channel or is switched off. Routing entries are written into a shadow table and committed atomically to the active table at a quiet cycle, so no output ever sees a half-updated route. Each output carries a valid strobe alongside its data, one pipeline stage after the input.

## Interface
- W_CHAN, 16, width of each data channel
- W_SEL, 4, width of source/destination select; requires 2^W_SEL ≥ max(N_IN, N_OUT)
- N_IN, 8, number of input channels
- N_OUT, 8, number of output channels
- ACTV_INIT, 1, reset value of every output's active bit
- COMMIT_TMO, 64, cycles an armed commit waits for a quiet cycle before forcing
- clk_in  input  1  system clock; one clock domain, all logic on rising edge
- rst_in  input  1  reset, synchronous, active-high
- data_packed_in  input  W_CHAN*N_IN  input channels, channel i at [i*W_CHAN +: W_CHAN]
- data_valid_in  input  N_IN  per-input sample strobe
- cfg_src_in  input  W_SEL  source channel for the entry being written
- cfg_dest_in  input  W_SEL  destination output for the entry being written
- cfg_active_in  input  1  active bit for the entry being written
- cfg_write_in  input  1  one-cycle pulse that writes the entry into the shadow table
- cfg_commit_in  input  1  one-cycle pulse that requests shadow→active copy
- data_packed_out  output  W_CHAN*N_OUT  routed channels, same packing as the input
- data_valid_out  output  N_OUT  per-output strobe
- commit_done_out  output  1  one-cycle pulse on the cycle after the active table updates
- cfg_err_out  output  1  one-cycle pulse flagging a rejected write

## Operation
- Table entry is {active, src}. Reset value: src=0, active=ACTV_INIT, in both the shadow and active tables.
- Write: when cfg_write_in=1 and cfg_dest_in<N_OUT, shadow[cfg_dest_in] ← {cfg_active_in, cfg_src_in}.
- Rejected write: when cfg_dest_in≥N_OUT, nothing is written and cfg_err_out pulses on the next cycle.
- A cfg_src_in≥N_IN value is stored as given. Outputs routed to such a source act inactive.
- Datapath, per output k, registered: data_out[k] ← data_packed_in[src[k]], valid_out[k] ← active[k] & data_valid_in[src[k]].
- Inactive output (active=0 or src out of range): valid=0, data=0 (see Configuration).
- Commit FSM, states IDLE and ARMED:
  - IDLE: cfg_commit_in → ARMED, timeout counter cleared.
  - ARMED: commits on the first cycle where data_valid_in==0, or when the counter reaches COMMIT_TMO−1. On commit: active ← shadow, counter cleared, next state IDLE.
  - ARMED, no commit: counter increments. cfg_commit_in is ignored.
- A commit can occur on the same cycle as the request if that cycle is already quiet.
- Write and commit in the same cycle: the write lands in shadow first and the commit includes it.
- Writes during ARMED update shadow. They are included if they arrive on or before the commit cycle.
- Reset mid-ARMED: state returns to IDLE, both tables return to reset values, no commit_done_out pulse.

## Timing
- Outputs after reset: data_packed_out=0, data_valid_out=0, commit_done_out=0, cfg_err_out=0.
- Data latency: 1 cycle from data_valid_in/data_packed_in to data_valid_out/data_packed_out.
- The datapath uses the active table as registered at the sampling edge. A sample on the commit cycle still uses the old route.
- commit_done_out pulses 1 cycle after the active-table update. The first routed sample with the new table appears on the same cycle.
- Worst-case commit latency from cfg_commit_in: COMMIT_TMO cycles.
- Throughput: one sample per input per cycle, no backpressure.

## Configuration
- STREAM_ROUTER_HOLD_EN
  - Defined: an inactive output holds its last driven data word; valid stays 0.
  - Undefined: an inactive output drives data 0.
  - Reset value is 0 in both cases.

## Structure
- Package stream_router_pkg:
  - commit FSM state enum (IDLE, ARMED)
  - route-entry struct {active, src} and its width function of W_SEL
  - default constants
- Sub-module stream_router_table: shadow and active tables, write decode, range check, commit FSM, timeout counter. It exports the active table packed.
- Top level: the N_OUT mux and output register array.

## Test plan
- Reset, then drive input 0 with 0x1234 and valid → every output shows 0x1234 with valid=1 one cycle later (ACTV_INIT=1).
- Write dest=3, src=5, active=1, then commit with inputs idle → commit_done_out pulses 2 cycles after cfg_commit_in; output 3 tracks input 5.
- Commit while data_valid_in is held nonzero → no update for COMMIT_TMO−1 cycles, then forced commit and commit_done_out pulse.
- Write dest=N_OUT (e.g. 8 with W_SEL=4) → cfg_err_out pulses once; the shadow table is unchanged, checked by a later commit.
- Write dest=2 active=0, commit, then drive input 0 with 0xBEEF → output 2 has valid=0 and data 0 (macro off) or its last value (macro on).
- Assert rst_in while ARMED with a pending write → no commit_done_out pulse; all routes return to src 0 with active=ACTV_INIT.

Source files
------------

// File: rtl/stream_router_pkg.sv
// rtl/stream_router_pkg.sv - shared types and defaults for the stream router
// Purpose: commit FSM state enum, route-entry layout, default parameter values.
// Build option: STREAM_ROUTER_HOLD_EN (consumed in rtl/stream_router.sv).
package stream_router_pkg;

   localparam int DEF_W_CHAN     = 16;
   localparam int DEF_W_SEL      = 4;
   localparam int DEF_N_IN       = 8;
   localparam int DEF_N_OUT      = 8;
   localparam int DEF_COMMIT_TMO = 64;
   localparam bit DEF_ACTV_INIT  = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } commit_state_t;

   // Route entry layout at default width: active bit above the source select.
   typedef struct packed {
      logic                 active;
      logic [DEF_W_SEL-1:0] src;
   } route_entry_t;

   // Packed width of one {active, src} entry for a given select width.
   function automatic int entry_w(input int w_sel);
      return w_sel + 1;
   endfunction

endpackage

// File: rtl/stream_router_if.sv
// rtl/stream_router_if.sv - data and configuration bundle of the stream router
// Purpose: groups the routed data streams, configuration strobes and status pulses.
// Ports (router view, modport slave):
//   in : data_packed_in, data_valid_in, cfg_src_in, cfg_dest_in, cfg_active_in,
//        cfg_write_in, cfg_commit_in
//   out: data_packed_out, data_valid_out, commit_done_out, cfg_err_out
// Modport master is the driving side (source of data and configuration).
interface stream_router_if #(
   parameter int W_CHAN = 16,
   parameter int W_SEL  = 4,
   parameter int N_IN   = 8,
   parameter int N_OUT  = 8
);
   logic [W_CHAN*N_IN-1:0]  data_packed_in;
   logic [N_IN-1:0]         data_valid_in;
   logic [W_SEL-1:0]        cfg_src_in;
   logic [W_SEL-1:0]        cfg_dest_in;
   logic                    cfg_active_in;
   logic                    cfg_write_in;
   logic                    cfg_commit_in;
   logic [W_CHAN*N_OUT-1:0] data_packed_out;
   logic [N_OUT-1:0]        data_valid_out;
   logic                    commit_done_out;
   logic                    cfg_err_out;

   modport slave (
      input  data_packed_in, data_valid_in, cfg_src_in, cfg_dest_in,
             cfg_active_in, cfg_write_in, cfg_commit_in,
      output data_packed_out, data_valid_out, commit_done_out, cfg_err_out
   );

   modport master (
      output data_packed_in, data_valid_in, cfg_src_in, cfg_dest_in,
             cfg_active_in, cfg_write_in, cfg_commit_in,
      input  data_packed_out, data_valid_out, commit_done_out, cfg_err_out
   );
endinterface

// File: rtl/stream_router_table.sv
// rtl/stream_router_table.sv - shadow/active route tables and commit FSM
// Purpose: decodes configuration writes into the shadow table, rejects
//   out-of-range destinations, and copies shadow to active on a quiet cycle
//   or after COMMIT_TMO cycles of waiting.
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   i_quiet             no input strobe asserted this cycle
//   i_cfg_*             entry write and commit request strobes
//   o_active_packed     active table, entry k at [k*EW +: EW], EW = W_SEL+1
//   o_commit_done       pulse one cycle after the active table updates
//   o_cfg_err           pulse one cycle after a rejected write
module stream_router_table
   import stream_router_pkg::*;
#(
   parameter int W_SEL      = DEF_W_SEL,
   parameter int N_OUT      = DEF_N_OUT,
   parameter bit ACTV_INIT  = DEF_ACTV_INIT,
   parameter int COMMIT_TMO = DEF_COMMIT_TMO
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            i_quiet,
   input  logic [W_SEL-1:0]                i_cfg_src,
   input  logic [W_SEL-1:0]                i_cfg_dest,
   input  logic                            i_cfg_active,
   input  logic                            i_cfg_write,
   input  logic                            i_cfg_commit,
   output logic [N_OUT*entry_w(W_SEL)-1:0] o_active_packed,
   output logic                            o_commit_done,
   output logic                            o_cfg_err
);
   localparam int EW = entry_w(W_SEL);
   localparam int CW = (COMMIT_TMO > 2) ? $clog2(COMMIT_TMO) : 1;
   localparam logic [EW-1:0] RST_ENTRY = {ACTV_INIT, {W_SEL{1'b0}}};

   logic [EW-1:0]  r_shadow [N_OUT];
   logic [EW-1:0]  r_active [N_OUT];
   logic [EW-1:0]  w_shadow_nxt [N_OUT];
   commit_state_t  r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           w_commit;
   logic           w_dest_ok;
   logic           r_commit_d;

   assign w_dest_ok = ({1'b0, i_cfg_dest} < EW'(N_OUT));

   // The write is folded in ahead of the commit copy, so a same-cycle write
   // is part of the committed table.
   always_comb begin
      for (int k = 0; k < N_OUT; k++) begin
         w_shadow_nxt[k] = r_shadow[k];
         if (i_cfg_write && w_dest_ok && (i_cfg_dest == W_SEL'(k)))
            w_shadow_nxt[k] = {i_cfg_active, i_cfg_src};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cfg_commit) begin
               w_cnt_nxt = '0;
               if (i_quiet) w_commit = 1'b1;
               else         w_state_nxt = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // Further commit requests while armed are ignored.
            if (i_quiet || (r_cnt == CW'(COMMIT_TMO - 1))) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_commit_d    <= 1'b0;
         o_commit_done <= 1'b0;
         o_cfg_err     <= 1'b0;
         for (int k = 0; k < N_OUT; k++) begin
            r_shadow[k] <= RST_ENTRY;
            r_active[k] <= RST_ENTRY;
         end
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_commit_d    <= w_commit;
         o_commit_done <= r_commit_d;
         o_cfg_err     <= i_cfg_write & ~w_dest_ok;
         for (int k = 0; k < N_OUT; k++) begin
            r_shadow[k] <= w_shadow_nxt[k];
            if (w_commit) r_active[k] <= w_shadow_nxt[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N_OUT; k++)
         o_active_packed[k*EW +: EW] = r_active[k];
   end

endmodule

// File: rtl/stream_router.sv
// rtl/stream_router.sv - registered N_IN to N_OUT channel router
// Purpose: each output selects one input channel through the committed route
//   table, registered one cycle after the input, or is switched off.
// Ports:
//   clk_in   system clock, rising edge
//   rst_in   synchronous active-high reset
//   bus      stream_router_if.slave: input channels/strobes, configuration,
//            routed outputs/strobes, commit_done_out and cfg_err_out pulses
// Build option: STREAM_ROUTER_HOLD_EN - when defined an inactive output holds
//   its last data word instead of driving 0; valid is 0 either way.
module stream_router
   import stream_router_pkg::*;
#(
   parameter int W_CHAN     = DEF_W_CHAN,
   parameter int W_SEL      = DEF_W_SEL,
   parameter int N_IN       = DEF_N_IN,
   parameter int N_OUT      = DEF_N_OUT,
   parameter bit ACTV_INIT  = DEF_ACTV_INIT,
   parameter int COMMIT_TMO = DEF_COMMIT_TMO
) (
   input  logic           clk_in,
   input  logic           rst_in,
   stream_router_if.slave bus
);
   localparam int EW = entry_w(W_SEL);

   logic [N_OUT*EW-1:0] w_active_packed;
   logic                w_quiet;

   assign w_quiet = (bus.data_valid_in == '0);

   stream_router_table #(
      .W_SEL      (W_SEL),
      .N_OUT      (N_OUT),
      .ACTV_INIT  (ACTV_INIT),
      .COMMIT_TMO (COMMIT_TMO)
   ) u_table (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .i_quiet         (w_quiet),
      .i_cfg_src       (bus.cfg_src_in),
      .i_cfg_dest      (bus.cfg_dest_in),
      .i_cfg_active    (bus.cfg_active_in),
      .i_cfg_write     (bus.cfg_write_in),
      .i_cfg_commit    (bus.cfg_commit_in),
      .o_active_packed (w_active_packed),
      .o_commit_done   (bus.commit_done_out),
      .o_cfg_err       (bus.cfg_err_out)
   );

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      logic [W_SEL-1:0]  w_src;
      logic              w_act;
      logic              w_on;
      logic [W_CHAN-1:0] w_sel_data;
      logic              w_sel_valid;
      logic [W_CHAN-1:0] r_data;
      logic              r_valid;

      assign w_src = w_active_packed[k*EW +: W_SEL];
      assign w_act = w_active_packed[k*EW + W_SEL];
      // A source select past the last input is treated as switched off.
      assign w_on  = w_act & ({1'b0, w_src} < EW'(N_IN));

      always_comb begin
         w_sel_data  = '0;
         w_sel_valid = 1'b0;
         for (int i = 0; i < N_IN; i++) begin
            if (w_src == W_SEL'(i)) begin
               w_sel_data  = bus.data_packed_in[i*W_CHAN +: W_CHAN];
               w_sel_valid = bus.data_valid_in[i];
            end
         end
      end

      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            r_data  <= '0;
            r_valid <= 1'b0;
         end else begin
            r_valid <= w_on & w_sel_valid;
            if (w_on) r_data <= w_sel_data;
`ifdef STREAM_ROUTER_HOLD_EN
            else      r_data <= r_data;
`else
            else      r_data <= '0;
`endif
         end
      end

      assign bus.data_packed_out[k*W_CHAN +: W_CHAN] = r_data;
      assign bus.data_valid_out[k]                    = r_valid;
   end

endmodule

// File: tb/tb_stream_router.sv
// tb/tb_stream_router.sv - directed self-checking bench for stream_router
module tb_stream_router;
   localparam int W_CHAN = 16;
   localparam int W_SEL  = 4;
   localparam int N_IN   = 8;
   localparam int N_OUT  = 8;
   localparam int TMO    = 64;
`ifdef STREAM_ROUTER_HOLD_EN
   localparam logic [15:0] OFF_W = 16'h7777;
`else
   localparam logic [15:0] OFF_W = 16'h0000;
`endif

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   n;

   stream_router_if #(.W_CHAN(W_CHAN), .W_SEL(W_SEL), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

   stream_router #(
      .W_CHAN(W_CHAN), .W_SEL(W_SEL), .N_IN(N_IN), .N_OUT(N_OUT),
      .ACTV_INIT(1'b1), .COMMIT_TMO(TMO)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] dest, input logic [3:0] src, input logic act);
      bus.cfg_dest_in   = dest;
      bus.cfg_src_in    = src;
      bus.cfg_active_in = act;
      bus.cfg_write_in  = 1'b1;
      step();
      bus.cfg_write_in  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.data_packed_in = '0;
      bus.data_valid_in  = '0;
      bus.cfg_src_in     = '0;
      bus.cfg_dest_in    = '0;
      bus.cfg_active_in  = 1'b0;
      bus.cfg_write_in   = 1'b0;
      bus.cfg_commit_in  = 1'b0;
      step();
      step();
      check("rst_data",  bus.data_packed_out, 128'h0);
      check("rst_valid", bus.data_valid_out, 8'h00);
      check("rst_done",  bus.commit_done_out, 1'b0);
      check("rst_err",   bus.cfg_err_out, 1'b0);
      rst = 1'b0;

      // Every output follows input 0 out of reset.
      bus.data_packed_in = 128'h1234;
      bus.data_valid_in  = 8'h01;
      step();
      check("bcast_data",  bus.data_packed_out, {8{16'h1234}});
      check("bcast_valid", bus.data_valid_out, 8'hFF);
      bus.data_packed_in = '0;
      bus.data_valid_in  = '0;
      step();

      // Route output 3 to input 5, commit on a quiet cycle.
      wr(4'd3, 4'd5, 1'b1);
      bus.cfg_commit_in = 1'b1;
      step();
      bus.cfg_commit_in = 1'b0;
      check("q_done_c1", bus.commit_done_out, 1'b0);
      step();
      check("q_done_c2", bus.commit_done_out, 1'b1);
      step();
      check("q_done_c3", bus.commit_done_out, 1'b0);
      bus.data_packed_in = {16'h0, 16'h0, 16'hA5A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1111};
      bus.data_valid_in  = 8'h21;
      step();
      check("r3_data", bus.data_packed_out,
            {16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'hA5A5, 16'h1111, 16'h1111, 16'h1111});
      check("r3_valid", bus.data_valid_out, 8'hFF);

      // Busy inputs: commit is forced by the timeout.
      bus.data_packed_in = {16'h0, 16'h0, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h3333, 16'h2222};
      bus.data_valid_in  = 8'h01;
      wr(4'd4, 4'd1, 1'b1);
      bus.cfg_commit_in = 1'b1;
      step();
      bus.cfg_commit_in = 1'b0;
      n = 1;
      while (!bus.commit_done_out && n < 100) begin
         step();
         n++;
      end
      check("tmo_cycles", n, TMO + 2);
      check("tmo_data", bus.data_packed_out,
            {16'h2222, 16'h2222, 16'h2222, 16'h3333, 16'h5555, 16'h2222, 16'h2222, 16'h2222});
      check("tmo_valid", bus.data_valid_out, 8'hE7);
      bus.data_packed_in = '0;
      bus.data_valid_in  = '0;
      step();

      // Destination out of range is rejected and leaves the shadow table alone.
      wr(4'd8, 4'd7, 1'b0);
      check("err_pulse", bus.cfg_err_out, 1'b1);
      step();
      check("err_clear", bus.cfg_err_out, 1'b0);
      bus.cfg_commit_in = 1'b1;
      step();
      bus.cfg_commit_in = 1'b0;
      step();
      check("err_commit_done", bus.commit_done_out, 1'b1);
      bus.data_packed_in = {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
      bus.data_valid_in  = 8'hFF;
      step();
      check("err_data", bus.data_packed_out,
            {16'h1000, 16'h1000, 16'h1000, 16'h1001, 16'h1005, 16'h1000, 16'h1000, 16'h1000});
      check("err_valid", bus.data_valid_out, 8'hFF);

      // Output 2 switched off, output 7 routed to a nonexistent input.
      bus.data_packed_in = 128'h7777;
      bus.data_valid_in  = 8'h00;
      step();
      wr(4'd2, 4'd0, 1'b0);
      wr(4'd7, 4'd9, 1'b1);
      bus.cfg_commit_in = 1'b1;
      step();
      bus.cfg_commit_in = 1'b0;
      step();
      check("off_done", bus.commit_done_out, 1'b1);
      check("off_out2_commit", bus.data_packed_out[47:32], OFF_W);
      bus.data_packed_in = 128'hBEEF;
      bus.data_valid_in  = 8'h01;
      step();
      check("off_valid", bus.data_valid_out, 8'h63);
      check("off_data", bus.data_packed_out,
            {OFF_W, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000, OFF_W, 16'hBEEF, 16'hBEEF});

      // Reset while armed with a pending write.
      bus.data_packed_in = '0;
      bus.data_valid_in  = 8'hFF;
      bus.cfg_commit_in  = 1'b1;
      step();
      bus.cfg_commit_in  = 1'b0;
      wr(4'd6, 4'd7, 1'b1);
      step();
      rst = 1'b1;
      step();
      check("rstarm_done", bus.commit_done_out, 1'b0);
      check("rstarm_valid", bus.data_valid_out, 8'h00);
      rst = 1'b0;
      bus.data_valid_in = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rstarm_no_done", bus.commit_done_out, 1'b0);
      end
      bus.cfg_commit_in = 1'b1;
      step();
      bus.cfg_commit_in = 1'b0;
      step();
      check("rstarm_recommit", bus.commit_done_out, 1'b1);
      bus.data_packed_in = {16'h2007, 16'h2006, 16'h2005, 16'h2004, 16'h2003, 16'h2002, 16'h2001, 16'h2000};
      bus.data_valid_in  = 8'hFF;
      step();
      check("rstarm_data", bus.data_packed_out, {8{16'h2000}});
      check("rstarm_route_valid", bus.data_valid_out, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
